// File: rtl/elastic_operand_join.sv
// Operand join stage ahead of the elastic ALU: two valid/stop operand
// channels, each buffered in a small FIFO, merged into one valid/stop
// channel whose readiness depends only on the operands the opcode uses.

module eoj_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_valid,
    input  logic [DATA_WIDTH-1:0]        push_data,
    output logic                         push_stop,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;

    // Full is decoded from the registered count only, so a same-cycle pop
    // never lets a push in; the freed slot shows up one cycle later.
    assign push_stop = (count == FULL);
    assign push      = push_valid & ~push_stop;
    assign head      = (count != '0) ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

module elastic_operand_join #(
    parameter int DATA_WIDTH           = 32,
    parameter int OPERATION_BIT_LENGTH = 4,
    parameter int DEPTH                = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [OPERATION_BIT_LENGTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]           in1_data,
    input  logic                            in1_valid,
    output logic                            in1_stop,
    input  logic [DATA_WIDTH-1:0]           in2_data,
    input  logic                            in2_valid,
    output logic                            in2_stop,
    output logic [DATA_WIDTH-1:0]           out_data_1,
    output logic [DATA_WIDTH-1:0]           out_data_2,
    output logic                            valid_output,
    input  logic                            stop_output,
    output logic [$clog2(DEPTH):0]          fifo1_count,
    output logic [$clog2(DEPTH):0]          fifo2_count
);
    localparam int OW = OPERATION_BIT_LENGTH;
    localparam logic [OW-1:0] OP_NOP   = OW'(0);
    localparam logic [OW-1:0] OP_CONST = OW'(5);
    localparam logic [OW-1:0] OP_LOAD  = OW'(6);
    localparam logic [OW-1:0] OP_ROUTE = OW'(8);

    logic need1;
    logic need2;
    logic out_transfer;

    // Opcode to operand-need decode; unknown opcodes are treated as binary.
    always_comb begin
        need1 = 1'b1;
        need2 = 1'b1;
        if (op == OP_NOP || op == OP_CONST) begin
            need1 = 1'b0;
            need2 = 1'b0;
        end else if (op >= OP_LOAD && op <= OP_ROUTE) begin
            need2 = 1'b0;
        end
    end

    assign valid_output = (~need1 | (fifo1_count != '0)) &
                          (~need2 | (fifo2_count != '0));
    assign out_transfer = valid_output & ~stop_output;

    eoj_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (in1_valid),
        .push_data  (in1_data),
        .push_stop  (in1_stop),
        .pop        (out_transfer & need1),
        .head       (out_data_1),
        .count      (fifo1_count)
    );

    eoj_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (in2_valid),
        .push_data  (in2_data),
        .push_stop  (in2_stop),
        .pop        (out_transfer & need2),
        .head       (out_data_2),
        .count      (fifo2_count)
    );
endmodule

// File: tb/tb_elastic_operand_join.sv
// Directed bench for elastic_operand_join: queue-based reference model
// checked every cycle, plus hand-computed spot checks along the vectors.

module tb_elastic_operand_join;
    localparam int DW    = 32;
    localparam int OBL   = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [OBL-1:0] op;
    logic [DW-1:0]  in1_data, in2_data;
    logic           in1_valid, in2_valid;
    logic           in1_stop, in2_stop;
    logic [DW-1:0]  out_data_1, out_data_2;
    logic           valid_output;
    logic           stop_output;
    logic [CW-1:0]  fifo1_count, fifo2_count;

    int n_assert = 0;
    int n_fail   = 0;

    elastic_operand_join #(.DATA_WIDTH(DW), .OPERATION_BIT_LENGTH(OBL), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op           (op),
        .in1_data     (in1_data),
        .in1_valid    (in1_valid),
        .in1_stop     (in1_stop),
        .in2_data     (in2_data),
        .in2_valid    (in2_valid),
        .in2_stop     (in2_stop),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .valid_output (valid_output),
        .stop_output  (stop_output),
        .fifo1_count  (fifo1_count),
        .fifo2_count  (fifo2_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // bit0 = operand 1 needed, bit1 = operand 2 needed
    function automatic logic [1:0] need_of(input logic [OBL-1:0] o);
        if (o == 0 || o == 5) return 2'b00;
        if (o >= 6 && o <= 8) return 2'b01;
        return 2'b11;
    endfunction

    // Reference model: each FIFO is a plain queue.
    logic [DW-1:0]  q1[$];
    logic [DW-1:0]  q2[$];
    logic           m_hold = 1'b0;
    logic [OBL-1:0] hold_op = '0;

    function automatic logic model_valid(input logic [OBL-1:0] o);
        logic [1:0] n;
        n = need_of(o);
        return (!n[0] || q1.size() != 0) && (!n[1] || q2.size() != 0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [1:0] n;
        logic       v, a1, a2;
        if (!reset_n) begin
            q1.delete();
            q2.delete();
            m_hold = 1'b0;
        end else begin
            if (m_hold) chk("op_stable_while_held", op, hold_op);
            n  = need_of(op);
            v  = model_valid(op);
            a1 = in1_valid && q1.size() < DEPTH;
            a2 = in2_valid && q2.size() < DEPTH;
            if (v && !stop_output) begin
                if (n[0]) void'(q1.pop_front());
                if (n[1]) void'(q2.pop_front());
            end
            if (a1) q1.push_back(in1_data);
            if (a2) q2.push_back(in2_data);
            m_hold  = v && stop_output;
            hold_op = op;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("valid_output", valid_output, model_valid(op));
            chk("out_data_1", out_data_1, (q1.size() != 0) ? q1[0] : '0);
            chk("out_data_2", out_data_2, (q2.size() != 0) ? q2[0] : '0);
            chk("fifo1_count", fifo1_count, q1.size());
            chk("fifo2_count", fifo2_count, q2.size());
            chk("in1_stop", in1_stop, q1.size() == DEPTH);
            chk("in2_stop", in2_stop, q2.size() == DEPTH);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic d1(input logic v, input logic [DW-1:0] d);
        in1_valid = v;
        in1_data  = d;
    endtask

    task automatic d2(input logic v, input logic [DW-1:0] d);
        in2_valid = v;
        in2_data  = d;
    endtask

    initial begin
        reset_n     = 1'b0;
        op          = 4'd5;
        stop_output = 1'b0;
        d1(0, 0);
        d2(0, 0);
        #3;
        // No-operand opcode is valid even while held in reset
        chk("rst_valid_const", valid_output, 1);
        chk("rst_cnt1", fifo1_count, 0);
        chk("rst_cnt2", fifo2_count, 0);
        chk("rst_stop1", in1_stop, 0);
        chk("rst_out1", out_data_1, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // const opcode, stalled output: nothing changes
        chk("const_valid", valid_output, 1);
        stop_output = 1'b1;
        repeat (3) begin
            tick();
            chk("const_stall_valid", valid_output, 1);
            chk("const_stall_cnt1", fifo1_count, 0);
        end
        stop_output = 1'b0;
        tick();

        // op=1, simultaneous operands
        op = 4'd1;
        d1(1, 5); d2(1, 7);
        tick();
        chk("t1_valid", valid_output, 1);
        chk("t1_o1", out_data_1, 5);
        chk("t1_o2", out_data_2, 7);
        d1(0, 0); d2(0, 0);
        tick();
        chk("t1_drained_valid", valid_output, 0);
        chk("t1_drained_cnt1", fifo1_count, 0);

        // op=1, in1 fills while in2 idle
        d1(1, 10); tick();
        d1(1, 11); tick();
        chk("t2_cnt1_full", fifo1_count, 2);
        chk("t2_stop1", in1_stop, 1);
        chk("t2_valid0", valid_output, 0);
        d1(1, 12); tick();
        chk("t2_held_cnt1", fifo1_count, 2);
        d2(1, 1); tick();
        chk("t2_pair_valid", valid_output, 1);
        chk("t2_pair_o1", out_data_1, 10);
        chk("t2_pair_o2", out_data_2, 1);
        d2(0, 0); tick();
        chk("t2_stop1_drop", in1_stop, 0);
        chk("t2_cnt1_after_pop", fifo1_count, 1);
        tick();
        d1(0, 0);
        chk("t2_12_accepted", fifo1_count, 2);
        d2(1, 2); tick();
        d2(1, 3); tick();
        d2(0, 0); tick();
        chk("t2_empty", fifo1_count, 0);

        // op=8, stream on in1 while in2 holds 99
        op = 4'd8;
        d2(1, 99); d1(1, 1); tick();
        d2(0, 0);
        chk("t3_o1_first", out_data_1, 1);
        d1(1, 2); tick();
        d1(1, 3); tick();
        d1(1, 4); tick();
        chk("t3_o1_last", out_data_1, 4);
        d1(0, 0); tick();
        chk("t3_cnt2_kept", fifo2_count, 1);
        chk("t3_o2_kept", out_data_2, 99);
        chk("t3_valid0", valid_output, 0);
        op = 4'd1;
        d1(1, 0); tick();
        d1(0, 0); tick();

        // op=3, both full then stalled
        op = 4'd3;
        stop_output = 1'b1;
        d1(1, 2); d2(1, 3); tick();
        d1(1, 4); d2(1, 5); tick();
        d1(0, 0); d2(0, 0);
        chk("t5_stop1_full", in1_stop, 1);
        chk("t5_stop2_full", in2_stop, 1);
        tick();
        chk("t5_hold_o1", out_data_1, 2);
        chk("t5_hold_o2", out_data_2, 3);
        stop_output = 1'b0;
        tick();
        chk("t5_second_o1", out_data_1, 4);
        chk("t5_second_o2", out_data_2, 5);
        d1(1, 6); d2(1, 7); tick();
        d1(0, 0); d2(0, 0);
        chk("t5_cnt_const", fifo1_count, 1);
        chk("t5_third_o1", out_data_1, 6);
        tick();
        tick();

        // mid-stream async reset
        op = 4'd1;
        d1(1, 20); tick();
        tick();
        d1(0, 0);
        chk("t6_cnt1_pre", fifo1_count, 2);
        reset_n = 1'b0;
        #2;
        chk("t6_cnt1_async", fifo1_count, 0);
        chk("t6_stop1_async", in1_stop, 0);
        chk("t6_o1_async", out_data_1, 0);
        tick();
        reset_n = 1'b1;
        d1(1, 30); d2(1, 31);
        chk("t6_not_yet", valid_output, 0);
        tick();
        d1(0, 0); d2(0, 0);
        chk("t6_first_valid", valid_output, 1);
        chk("t6_first_o1", out_data_1, 30);
        chk("t6_first_o2", out_data_2, 31);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
